vga_pong_renderer: RTL and testbench

- Downstream consumer of the 1024x768@60 timing bus `VGA_Ctrl`.
- Runs a single-player ball/paddle game: state updates once per frame; draws ball, paddle and background per pixel.
- Drives registered 4:4:4 RGB plus re-timed hsync/vsync to the board VGA pins, one clock after the bus.

---
 rtl/vga_game_pkg.sv | 40 ++++
 rtl/vga_ball_physics.sv | 185 ++++++++++++++++++
 rtl/vga_pong_renderer.sv | 136 +++++++++++++
 tb/tb_vga_pong_renderer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_game_pkg.sv
`default_nettype none
// ============================================================================
// Package : vga_game_pkg
// Brief   : Shared constants for the pong renderer: active area, VGA_Ctrl
//           bus field positions, game state encoding and 12-bit colours.
// Rev     : 1.0 - initial release
// ============================================================================
package vga_game_pkg;

    // Active display area of the 1024x768 timing bus
    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;

    // VGA_Ctrl bit-field positions: {visible, vs, hs, PixY, PixX, clk}
    localparam int BUS_VIS_BIT = 24;
    localparam int BUS_VS_BIT  = 23;
    localparam int BUS_HS_BIT  = 22;
    localparam int BUS_Y_MSB   = 21;
    localparam int BUS_Y_LSB   = 12;
    localparam int BUS_X_MSB   = 11;
    localparam int BUS_X_LSB   = 1;
    localparam int BUS_CLK_BIT = 0;

    // Game state encoding, visible on the game_state port
    typedef logic [1:0] game_state_t;
    localparam game_state_t ST_IDLE = 2'b00;
    localparam game_state_t ST_PLAY = 2'b01;
    localparam game_state_t ST_MISS = 2'b10;

    // 4:4:4 colours packed as {r, g, b}
    typedef logic [11:0] rgb_t;
    localparam rgb_t COL_BLANK   = 12'h000;
    localparam rgb_t COL_BALL    = 12'hFFF;
    localparam rgb_t COL_PADDLE  = 12'h0F0;
    localparam rgb_t COL_BG_PLAY = 12'h002;
    localparam rgb_t COL_BG_MISS = 12'h400;
    localparam rgb_t COL_BORDER  = 12'hAAA;

endpackage : vga_game_pkg
`default_nettype wire

// File: rtl/vga_ball_physics.sv
`default_nettype none
// ============================================================================
// Module : vga_ball_physics
// Brief  : Per-frame game update: paddle movement, ball motion with wall,
//          ceiling and paddle bounces, miss detection and the
//          IDLE/PLAY/MISS state machine. Everything advances only on tick.
// Rev    : 1.0 - initial release
// ============================================================================
module vga_ball_physics
    import vga_game_pkg::*;
#(
    parameter int BALL_SIZE    = 16,
    parameter int PADDLE_W     = 128,
    parameter int PADDLE_Y     = 720,
    parameter int BALL_SPEED   = 4,
    parameter int PADDLE_SPEED = 8,
    parameter int MISS_FRAMES  = 60
) (
    input  logic        clk75MHz,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [10:0] paddle_x,
    output logic [3:0]  miss_cnt,
    output game_state_t game_state
);

    localparam logic [10:0] BSZ          = 11'(BALL_SIZE);
    localparam logic [10:0] SPD          = 11'(BALL_SPEED);
    localparam logic [10:0] PSPD         = 11'(PADDLE_SPEED);
    localparam logic [10:0] PW           = 11'(PADDLE_W);
    localparam logic [10:0] PY           = 11'(PADDLE_Y);
    localparam logic [10:0] V_LIM        = 11'(V_ACTIVE);
    localparam logic [10:0] BALL_X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] BALL_X_HOME  = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y_HOME  = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y_REST  = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] PADDLE_HOME  = 11'((H_ACTIVE - PADDLE_W) / 2);
    localparam logic [10:0] PADDLE_X_MAX = 11'(H_ACTIVE - PADDLE_W);
    localparam int          CNT_W        = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
    localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_FRAMES - 1);

    game_state_t       state;
    game_state_t       state_next;
    logic              dx_pos;          // 1: moving right
    logic              dy_pos;          // 1: moving down
    logic              dx_pos_next;
    logic              dy_pos_next;
    logic [10:0]       ball_x_next;
    logic [10:0]       ball_y_next;
    logic [10:0]       paddle_x_next;
    logic [3:0]        miss_cnt_next;
    logic [CNT_W-1:0]  miss_frames;
    logic [CNT_W-1:0]  miss_frames_next;
    logic [10:0]       ball_bottom_next;
    logic              paddle_overlap;
    logic              paddle_hit;
    logic              floor_miss;
    logic              miss_done;

    // Collision terms use the positions held before this tick's update
    assign ball_bottom_next = ball_y + BSZ + SPD;
    assign paddle_overlap   = ((ball_x + BSZ) > paddle_x) && (ball_x < (paddle_x + PW));
    assign paddle_hit       = dy_pos && (ball_bottom_next >= PY) && paddle_overlap;
    assign floor_miss       = dy_pos && !paddle_hit && (ball_bottom_next >= V_LIM);
    assign miss_done        = (miss_frames == MISS_LAST);

    // State register and game datapath registers
    always_ff @(posedge clk75MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ball_x      <= BALL_X_HOME;
            ball_y      <= BALL_Y_HOME;
            dx_pos      <= 1'b1;
            dy_pos      <= 1'b1;
            paddle_x    <= PADDLE_HOME;
            miss_cnt    <= 4'd0;
            miss_frames <= '0;
        end else begin
            state       <= state_next;
            ball_x      <= ball_x_next;
            ball_y      <= ball_y_next;
            dx_pos      <= dx_pos_next;
            dy_pos      <= dy_pos_next;
            paddle_x    <= paddle_x_next;
            miss_cnt    <= miss_cnt_next;
            miss_frames <= miss_frames_next;
        end
    end

    // Next-state logic: transitions only happen on the frame tick
    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                ST_IDLE: if (btn_start)  state_next = ST_PLAY;
                ST_PLAY: if (floor_miss) state_next = ST_MISS;
                ST_MISS: if (miss_done)  state_next = ST_IDLE;
                default:                 state_next = ST_IDLE;
            endcase
        end
    end

    // Ball, paddle and counter updates for the coming frame
    always_comb begin
        ball_x_next      = ball_x;
        ball_y_next      = ball_y;
        dx_pos_next      = dx_pos;
        dy_pos_next      = dy_pos;
        paddle_x_next    = paddle_x;
        miss_cnt_next    = miss_cnt;
        miss_frames_next = miss_frames;
        if (tick) begin
            // Paddle moves in every state; pressing both buttons cancels out
            if (btn_left && !btn_right) begin
                paddle_x_next = (paddle_x < PSPD) ? 11'd0 : paddle_x - PSPD;
            end else if (btn_right && !btn_left) begin
                paddle_x_next = ((paddle_x + PSPD) > PADDLE_X_MAX) ? PADDLE_X_MAX : paddle_x + PSPD;
            end

            case (state)
                ST_PLAY: begin
                    // Horizontal axis: clamp to the wall and reverse
                    if (dx_pos) begin
                        if ((ball_x + SPD) >= BALL_X_MAX) begin
                            ball_x_next = BALL_X_MAX;
                            dx_pos_next = 1'b0;
                        end else begin
                            ball_x_next = ball_x + SPD;
                        end
                    end else if (ball_x < SPD) begin
                        ball_x_next = 11'd0;
                        dx_pos_next = 1'b1;
                    end else begin
                        ball_x_next = ball_x - SPD;
                    end

                    // Vertical axis: ceiling bounce, paddle bounce or miss;
                    // on a miss the ball stays where it was for the MISS screen
                    if (!dy_pos) begin
                        if (ball_y < SPD) begin
                            ball_y_next = 11'd0;
                            dy_pos_next = 1'b1;
                        end else begin
                            ball_y_next = ball_y - SPD;
                        end
                    end else if (paddle_hit) begin
                        ball_y_next = BALL_Y_REST;
                        dy_pos_next = 1'b0;
                    end else if (floor_miss) begin
                        miss_cnt_next = (miss_cnt == 4'hF) ? 4'hF : miss_cnt + 4'd1;
                    end else begin
                        ball_y_next = ball_y + SPD;
                    end
                end
                ST_MISS: begin
                    if (miss_done) begin
                        ball_x_next      = BALL_X_HOME;
                        ball_y_next      = BALL_Y_HOME;
                        dx_pos_next      = 1'b1;
                        dy_pos_next      = 1'b1;
                        miss_frames_next = '0;
                    end else begin
                        miss_frames_next = miss_frames + 1'b1;
                    end
                end
                default: begin
                    ball_x_next = BALL_X_HOME;
                    ball_y_next = BALL_Y_HOME;
                end
            endcase
        end
    end

    // State output
    always_comb begin
        game_state = state;
    end

endmodule : vga_ball_physics
`default_nettype wire

// File: rtl/vga_pong_renderer.sv
`default_nettype none
// ============================================================================
// Module : vga_pong_renderer
// Brief  : Single-player pong on the 1024x768 VGA_Ctrl timing bus. Derives the
//          frame tick, runs the game physics and renders ball / paddle /
//          background through one register stage, re-timing hsync/vsync
//          alongside the colour.
//          Optional: define VGA_BORDER_EN to draw a 4-pixel AAA frame border.
// Rev    : 1.0 - initial release
// ============================================================================
module vga_pong_renderer
    import vga_game_pkg::*;
#(
    parameter int BALL_SIZE    = 16,
    parameter int PADDLE_W     = 128,
    parameter int PADDLE_H     = 16,
    parameter int PADDLE_Y     = 720,
    parameter int BALL_SPEED   = 4,
    parameter int PADDLE_SPEED = 8,
    parameter int MISS_FRAMES  = 60
) (
    input  logic        clk75MHz,
    input  logic        rst_n,
    input  logic [24:0] VGA_Ctrl,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  miss_cnt,
    output logic [1:0]  game_state
);

    localparam logic [10:0] BSZ   = 11'(BALL_SIZE);
    localparam logic [10:0] PW    = 11'(PADDLE_W);
    localparam logic [10:0] PY    = 11'(PADDLE_Y);
    localparam logic [10:0] PY_END = 11'(PADDLE_Y + PADDLE_H);

    logic        bus_visible;
    logic        bus_vs;
    logic        bus_hs;
    logic [9:0]  pix_y;
    logic [10:0] pix_x;
    logic [10:0] pix_y_ext;
    logic        unused_bus_clk;   // bus clock copy is not needed here
    logic        frame_tick;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [10:0] paddle_x;
    logic        on_ball;
    logic        on_paddle;
    rgb_t        pixel_colour;

    assign bus_visible    = VGA_Ctrl[BUS_VIS_BIT];
    assign bus_vs         = VGA_Ctrl[BUS_VS_BIT];
    assign bus_hs         = VGA_Ctrl[BUS_HS_BIT];
    assign pix_y          = VGA_Ctrl[BUS_Y_MSB:BUS_Y_LSB];
    assign pix_x          = VGA_Ctrl[BUS_X_MSB:BUS_X_LSB];
    assign unused_bus_clk = VGA_Ctrl[BUS_CLK_BIT];
    assign pix_y_ext      = {1'b0, pix_y};

    // First pixel of the first blanking line marks the once-per-frame update
    assign frame_tick = (pix_x == 11'd0) && (pix_y == 10'(V_ACTIVE));

    vga_ball_physics #(
        .BALL_SIZE    (BALL_SIZE),
        .PADDLE_W     (PADDLE_W),
        .PADDLE_Y     (PADDLE_Y),
        .BALL_SPEED   (BALL_SPEED),
        .PADDLE_SPEED (PADDLE_SPEED),
        .MISS_FRAMES  (MISS_FRAMES)
    ) u_physics (
        .clk75MHz   (clk75MHz),
        .rst_n      (rst_n),
        .tick       (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_start  (btn_start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_x   (paddle_x),
        .miss_cnt   (miss_cnt),
        .game_state (game_state)
    );

    assign on_ball   = (pix_x >= ball_x) && (pix_x < (ball_x + BSZ)) &&
                       (pix_y_ext >= ball_y) && (pix_y_ext < (ball_y + BSZ));
    assign on_paddle = (pix_x >= paddle_x) && (pix_x < (paddle_x + PW)) &&
                       (pix_y_ext >= PY) && (pix_y_ext < PY_END);

`ifdef VGA_BORDER_EN
    logic on_border;
    assign on_border = (pix_x < 11'd4) || (pix_x >= 11'(H_ACTIVE - 4)) ||
                       (pix_y < 10'd4) || (pix_y >= 10'(V_ACTIVE - 4));
`endif

    // Colour selection: ball over paddle over (border) over background
    always_comb begin
        pixel_colour = COL_BLANK;
        if (bus_visible) begin
            if (on_ball) begin
                pixel_colour = COL_BALL;
            end else if (on_paddle) begin
                pixel_colour = COL_PADDLE;
`ifdef VGA_BORDER_EN
            end else if (on_border) begin
                pixel_colour = COL_BORDER;
`endif
            end else if (game_state == ST_MISS) begin
                pixel_colour = COL_BG_MISS;
            end else begin
                pixel_colour = COL_BG_PLAY;
            end
        end
    end

    // Output stage: colour and syncs registered together so they stay aligned
    always_ff @(posedge clk75MHz or negedge rst_n) begin
        if (!rst_n) begin
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            {vga_r, vga_g, vga_b} <= pixel_colour;
            vga_hs                <= bus_hs;
            vga_vs                <= bus_vs;
        end
    end

endmodule : vga_pong_renderer
`default_nettype wire

// File: tb/tb_vga_pong_renderer.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_pong_renderer
// Brief  : Self-checking bench for vga_pong_renderer. Drives VGA_Ctrl
//          directly (frame ticks and pixel probes), keeps a behavioural game
//          model and compares rendered pixels, syncs, state and miss count.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_vga_pong_renderer;

`ifdef VGA_BORDER_EN
    localparam logic [11:0] EDGE_BG = 12'hAAA;
`else
    localparam logic [11:0] EDGE_BG = 12'h002;
`endif

    logic        clk75MHz = 1'b0;
    logic        rst_n;
    logic [24:0] VGA_Ctrl;
    logic        btn_left;
    logic        btn_right;
    logic        btn_start;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  miss_cnt;
    logic [1:0]  game_state;

    always #5 clk75MHz = ~clk75MHz;

    vga_pong_renderer dut (
        .clk75MHz   (clk75MHz),
        .rst_n      (rst_n),
        .VGA_Ctrl   (VGA_Ctrl),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_start  (btn_start),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .miss_cnt   (miss_cnt),
        .game_state (game_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural game model: positions in pixels, velocities in signed pixels/frame
    int m_bx, m_by, m_vx, m_vy, m_px, m_state, m_miss, m_mfr;

    typedef struct {
        logic       vis;
        logic       hs;
        logic       vs;
        int         x;
        int         y;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_bx = 504; m_by = 376; m_vx = 4; m_vy = 4;
        m_px = 448; m_state = 0; m_miss = 0; m_mfr = 0;
    endfunction

    function automatic void model_tick(input logic l, input logic r, input logic s);
        int old_px;
        int old_bx;
        int nx;
        int bottom;
        old_px = m_px;
        old_bx = m_bx;
        case (m_state)
            0: if (s) m_state = 1;
            1: begin
                nx = m_bx + m_vx;
                if (nx >= 1008) begin
                    m_bx = 1008; m_vx = -4;
                end else if (nx < 0) begin
                    m_bx = 0; m_vx = 4;
                end else begin
                    m_bx = nx;
                end
                if (m_vy < 0) begin
                    if (m_by - 4 < 0) begin
                        m_by = 0; m_vy = 4;
                    end else begin
                        m_by = m_by - 4;
                    end
                end else begin
                    bottom = m_by + 16 + 4;
                    if (bottom >= 720 && old_bx + 16 > old_px && old_bx < old_px + 128) begin
                        m_by = 704; m_vy = -4;
                    end else if (bottom >= 768) begin
                        m_state = 2;
                        if (m_miss < 15) m_miss = m_miss + 1;
                    end else begin
                        m_by = m_by + 4;
                    end
                end
            end
            default: begin
                m_mfr = m_mfr + 1;
                if (m_mfr == 60) begin
                    m_bx = 504; m_by = 376; m_vx = 4; m_vy = 4;
                    m_mfr = 0; m_state = 0;
                end
            end
        endcase
        if (l && !r) m_px = (m_px - 8 < 0) ? 0 : m_px - 8;
        if (r && !l) m_px = (m_px + 8 > 896) ? 896 : m_px + 8;
    endfunction

    function automatic logic [11:0] model_rgb(input logic vis, input int x, input int y);
        if (!vis) return 12'h000;
        if (x >= m_bx && x < m_bx + 16 && y >= m_by && y < m_by + 16) return 12'hFFF;
        if (x >= m_px && x < m_px + 128 && y >= 720 && y < 736) return 12'h0F0;
`ifdef VGA_BORDER_EN
        if (x < 4 || x >= 1020 || y < 4 || y >= 764) return 12'hAAA;
`endif
        return (m_state == 2) ? 12'h400 : 12'h002;
    endfunction

    task automatic drive_bus(input logic vis, input logic hs, input logic vs, input int x, input int y);
        logic [9:0]  y10;
        logic [10:0] x11;
        logic        b0;
        y10 = 10'(y);
        x11 = 11'(x);
        b0  = 1'($urandom_range(0, 1));
        VGA_Ctrl = {vis, vs, hs, y10, x11, b0};
    endtask

    // One bus cycle with random syncs and random buttons (which must be ignored off-tick)
    task automatic probe_exp(input string name, input logic vis, input int x, input int y,
                             input logic [11:0] exp);
        logic hs, vs;
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        btn_left  = 1'($urandom_range(0, 1));
        btn_right = 1'($urandom_range(0, 1));
        btn_start = 1'($urandom_range(0, 1));
        drive_bus(vis, hs, vs, x, y);
        @(posedge clk75MHz);
        @(negedge clk75MHz);
        check(name, {vga_r, vga_g, vga_b}, exp);
        check({name, "/sync"}, {10'd0, vga_hs, vga_vs}, {10'd0, hs, vs});
    endtask

    task automatic probe(input string name, input int x, input int y);
        if (x >= 0 && x < 1024 && y >= 0 && y < 768)
            probe_exp(name, 1'b1, x, y, model_rgb(1'b1, x, y));
    endtask

    task automatic probe_scene();
        int rx, ry;
        probe("ball_tl", m_bx, m_by);
        probe("ball_br", m_bx + 15, m_by + 15);
        probe("ball_l", m_bx - 1, m_by);
        probe("ball_r", m_bx + 16, m_by + 15);
        probe("ball_t", m_bx + 7, m_by - 1);
        probe("ball_b", m_bx + 8, m_by + 16);
        probe("pad_tl", m_px, 720);
        probe("pad_br", m_px + 127, 735);
        probe("pad_l", m_px - 1, 728);
        probe("pad_r", m_px + 128, 728);
        probe("pad_t", m_px + 64, 719);
        probe("pad_b", m_px + 64, 736);
        for (int k = 0; k < 2; k++) begin
            rx = int'($urandom_range(0, 1023));
            ry = int'($urandom_range(0, 767));
            probe("rand_px", rx, ry);
        end
        rx = int'($urandom_range(1, 1343));
        ry = int'($urandom_range(0, 805));
        probe_exp("blank_px", 1'b0, rx, ry, 12'h000);
    endtask

    task automatic do_tick(input logic l, input logic r, input logic s);
        logic hs, vs;
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        drive_bus(1'b0, hs, vs, 0, 768);
        btn_left  = l;
        btn_right = r;
        btn_start = s;
        @(posedge clk75MHz);
        @(negedge clk75MHz);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_start = 1'b0;
        model_tick(l, r, s);
        check("tick_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("tick_sync", {10'd0, vga_hs, vga_vs}, {10'd0, hs, vs});
        check("game_state", {10'd0, game_state}, 12'(m_state));
        check("miss_cnt", {8'd0, miss_cnt}, 12'(m_miss));
        probe_scene();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        logic l, r, s;
        int   target, choice, guard;

        tbl = '{
            '{1'b1, 1'b0, 1'b1,  504, 376, 12'hFFF},
            '{1'b1, 1'b1, 1'b0,  519, 391, 12'hFFF},
            '{1'b1, 1'b1, 1'b1,  503, 376, 12'h002},
            '{1'b1, 1'b0, 1'b0,  520, 391, 12'h002},
            '{1'b1, 1'b1, 1'b1,  504, 375, 12'h002},
            '{1'b1, 1'b0, 1'b1,  519, 392, 12'h002},
            '{1'b1, 1'b1, 1'b1,    0,   0, EDGE_BG},
            '{1'b0, 1'b0, 1'b0,  512, 384, 12'h000},
            '{1'b0, 1'b1, 1'b1, 1100, 100, 12'h000},
            '{1'b1, 1'b1, 1'b1,  448, 720, 12'h0F0},
            '{1'b1, 1'b0, 1'b1,  575, 735, 12'h0F0},
            '{1'b1, 1'b1, 1'b0,  447, 720, 12'h002},
            '{1'b1, 1'b1, 1'b1,  576, 735, 12'h002},
            '{1'b1, 1'b0, 1'b0,  448, 736, 12'h002},
            '{1'b1, 1'b1, 1'b1,  448, 719, 12'h002},
            '{1'b1, 1'b0, 1'b0, 1023, 767, EDGE_BG}
        };

        // Reset with syncs driven low so the inactive-high reset value is visible
        rst_n = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
        drive_bus(1'b1, 1'b0, 1'b0, 504, 376);
        repeat (3) @(negedge clk75MHz);
        check("reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("reset_sync", {10'd0, vga_hs, vga_vs}, 12'h003);
        check("reset_state", {10'd0, game_state}, 12'h000);
        check("reset_miss", {8'd0, miss_cnt}, 12'h000);
        rst_n = 1'b1;
        model_reset();

        // Table of fixed pixels for the freshly reset IDLE scene
        for (int i = 0; i < 16; i++) begin
            drive_bus(tbl[i].vis, tbl[i].hs, tbl[i].vs, tbl[i].x, tbl[i].y);
            @(posedge clk75MHz);
            @(negedge clk75MHz);
            check($sformatf("tbl%0d_rgb", i), {vga_r, vga_g, vga_b}, tbl[i].rgb);
            check($sformatf("tbl%0d_sync", i), {10'd0, vga_hs, vga_vs}, {10'd0, tbl[i].hs, tbl[i].vs});
        end

        // Idle frame, then serve and take one step
        do_tick(1'b0, 1'b0, 1'b0);
        check("idle_after_tick", {10'd0, game_state}, 12'h000);
        do_tick(1'b0, 1'b0, 1'b1);
        check("serve_state", {10'd0, game_state}, 12'h001);
        do_tick(1'b0, 1'b0, 1'b0);
        probe_exp("first_step_ball", 1'b1, 508, 380, 12'hFFF);
        probe_exp("first_step_left", 1'b1, 507, 380, 12'h002);

        // Paddle stays at 448 while the ball falls to the right of it: miss
        guard = 0;
        while (m_state != 2 && guard < 200) begin
            do_tick(1'b0, 1'b0, 1'b0);
            guard++;
        end
        check("miss_state", {10'd0, game_state}, 12'h002);
        check("miss_count_one", {8'd0, miss_cnt}, 12'h001);
        probe_exp("miss_background", 1'b1, 200, 100, 12'h400);
        for (int i = 0; i < 59; i++) do_tick(1'b0, 1'b0, 1'b1);
        check("miss_hold_59", {10'd0, game_state}, 12'h002);
        do_tick(1'b0, 1'b0, 1'b0);
        check("miss_to_idle", {10'd0, game_state}, 12'h000);
        probe_exp("recentred_ball", 1'b1, 504, 376, 12'hFFF);

        // Paddle walks to the left wall and holds; both buttons cancel
        for (int i = 0; i < 60; i++) do_tick(1'b1, 1'b0, 1'b0);
        probe_exp("pad_left_edge", 1'b1, 0, 720, 12'h0F0);
        probe_exp("pad_left_end", 1'b1, 127, 735, 12'h0F0);
        probe_exp("pad_left_past", 1'b1, 128, 720, 12'h002);
        for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 1'b0);
        probe_exp("pad_both_hold", 1'b1, 128, 720, 12'h002);
        for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b1, 1'b0);
        probe_exp("pad_right_40", 1'b1, 40, 720, 12'h0F0);
        probe_exp("pad_right_39", 1'b1, 39, 720, 12'h002);

        // Randomised play: paddle mostly chases the ball so both hits and misses occur
        for (int t = 0; t < 800; t++) begin
            l = 1'b0; r = 1'b0;
            s = (m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            choice = int'($urandom_range(0, 9));
            if (choice < 7) begin
                target = m_bx + 8 - 64;
                if (m_px < target - 4) r = 1'b1;
                else if (m_px > target + 4) l = 1'b1;
            end else begin
                l = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
            end
            do_tick(l, r, s);
        end

        // Asynchronous reset in the middle of a visible line
        probe_exp("pre_reset_ball", 1'b1, m_bx, m_by, 12'hFFF);
        drive_bus(1'b1, 1'b0, 1'b0, m_bx, m_by);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("async_reset_sync", {10'd0, vga_hs, vga_vs}, 12'h003);
        check("async_reset_state", {10'd0, game_state}, 12'h000);
        check("async_reset_miss", {8'd0, miss_cnt}, 12'h000);
        @(negedge clk75MHz);
        rst_n = 1'b1;
        model_reset();
        probe_exp("post_reset_ball", 1'b1, 504, 376, 12'hFFF);
        probe_exp("post_reset_pad", 1'b1, 448, 720, 12'h0F0);
        probe_scene();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vga_pong_renderer
`default_nettype wire
